inst_reg_q: RTL

//  Parametrised instruction register: assembles BEATS bus words of DATA_W bits, MSB-beat first,

---
 rtl/inst_reg_q_if.sv | 27 ++
 rtl/inst_reg_q.sv | 92 +++++++++
 2 files changed

// File: rtl/inst_reg_q_if.sv
// Beat-input / instruction-output handshake bundle for inst_reg_q.
// The producer and consumer side of the bench drive the master modport; the register is the slave.
interface inst_reg_q_if #(
  parameter int DATA_W = 8,
  parameter int BEATS  = 2,
  parameter int OPC_W  = 3
);
  localparam int INS_W = DATA_W * BEATS;

  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_W-1:0]      data;
  logic                   out_valid;
  logic                   out_ready;
  logic [OPC_W-1:0]       opc;
  logic [INS_W-OPC_W-1:0] iraddr;

  modport master (
    output in_valid, data, out_ready,
    input  in_ready, out_valid, opc, iraddr
  );

  modport slave (
    input  in_valid, data, out_ready,
    output in_ready, out_valid, opc, iraddr
  );
endinterface

// File: rtl/inst_reg_q.sv
// Instruction register: assembles BEATS bus beats (MSB beat first) into one instruction
// and queues completed instructions in a DEPTH-entry FIFO split into opcode and address fields.
module inst_reg_q #(
  parameter int DATA_W = 8,
  parameter int BEATS  = 2,
  parameter int OPC_W  = 3,
  parameter int DEPTH  = 2,
  localparam int INS_W = DATA_W * BEATS,
  localparam int BI_W  = $clog2(BEATS) + 1,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  inst_reg_q_if.slave      bus,
  output logic [BI_W-1:0]  beat_idx,
  output logic [CNT_W-1:0] count
);

  logic [INS_W-1:0] asm_q;
  logic [INS_W-1:0] asm_next;
  logic [INS_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [INS_W-1:0] head;
  logic             accept;
  logic             last_beat;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready depends on registered occupancy only, so there is no path from out_ready.
  assign bus.in_ready  = (count < CNT_W'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign accept        = bus.in_valid && bus.in_ready;
  assign last_beat     = (beat_idx == BI_W'(BEATS - 1));
  assign push          = accept && last_beat && !flush;
  assign pop           = bus.out_valid && bus.out_ready && !flush;

  // Merge the incoming beat into its slot; the final beat goes straight into the FIFO.
  always_comb begin
    asm_next = asm_q;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_idx == BI_W'(k))
        asm_next[INS_W-1-k*DATA_W -: DATA_W] = bus.data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_idx <= '0;
      asm_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (flush) begin
      beat_idx <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (accept) begin
        asm_q    <= asm_next;
        beat_idx <= last_beat ? '0 : beat_idx + BI_W'(1);
      end
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; empty or flushed entries are masked at the outputs.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= asm_next;
  end

  assign head       = mem[rd_ptr];
  assign bus.opc    = bus.out_valid ? head[INS_W-1 -: OPC_W] : '0;
  assign bus.iraddr = bus.out_valid ? head[INS_W-OPC_W-1:0] : '0;

endmodule
